// File: rtl/vend_pkg.sv
// Shared definitions for the vending status transmitter: event codes, ASCII
// constants, FSM state types and the nibble-to-hex helper.
package vend_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [1:0] {
    EV_IDLE     = 2'd0,
    EV_PRICE    = 2'd1,
    EV_DISPENSE = 2'd2,
    EV_RSVD     = 2'd3
  } ev_code_e;

  localparam logic [7:0] ASCII_I    = 8'h49;
  localparam logic [7:0] ASCII_P    = 8'h50;
  localparam logic [7:0] ASCII_D    = 8'h44;
  localparam logic [7:0] ASCII_QM   = 8'h3F;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_ZERO = 8'h30;

  typedef enum logic [1:0] {
    B_IDLE = 2'd0,
    START  = 2'd1,
    DATA   = 2'd2,
    STOP   = 2'd3
  } byte_state_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } seq_state_e;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return ASCII_ZERO + {4'h0, nib};
    else             return 8'h37 + {4'h0, nib};
  endfunction

  function automatic logic [7:0] tag_ascii(input ev_code_e code);
    case (code)
      EV_IDLE:     return ASCII_I;
      EV_PRICE:    return ASCII_P;
      EV_DISPENSE: return ASCII_D;
      default:     return ASCII_QM;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte transmitter, LSB first. A start presented in the last STOP
// cycle chains the next frame with no idle gap.
module uart_tx_byte
  import vend_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done,
  output logic       active
);

  localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);

  byte_state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        last_cnt;

  assign last_cnt = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= B_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    if (state_q != B_IDLE) cnt_d = last_cnt ? '0 : cnt_q + 16'd1;
    case (state_q)
      B_IDLE: begin
        if (start) begin
          state_d = START;
          cnt_d   = '0;
          shift_d = data;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (last_cnt) begin
          state_d   = DATA;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
        end
      end
      DATA: begin
        if (last_cnt) begin
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end
      end
      STOP: begin
        if (last_cnt) begin
          if (start) begin
            state_d = START;
            shift_d = data;
            tx_d    = 1'b0;
          end else begin
            state_d = B_IDLE;
          end
        end
      end
      default: state_d = B_IDLE;
    endcase
  end

  always_comb begin
    tx     = tx_q;
    done   = (state_q == STOP) && last_cnt;
    active = (state_q != B_IDLE);
  end

endmodule

// File: rtl/vend_status_tx.sv
// Vending status reporter: captures one event and sends a 4-byte ASCII
// message (tag, item digit, price hex digit, LF) over the UART byte engine.
module vend_status_tx
  import vend_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       event_valid,
  input  logic [1:0] event_code,
  input  logic [1:0] event_item,
  input  logic [3:0] event_price,
  output logic       event_ready,
  output logic       tx,
  output logic       busy
);

  seq_state_e state_q, state_d;
  logic [1:0] idx_q, idx_d;
  ev_code_e   code_q, code_d;
  logic [1:0] item_q, item_d;
  logic [3:0] price_q, price_d;

  logic       accept;
  logic       eng_start;
  logic [7:0] eng_data;
  logic       eng_done;
  logic       eng_active;

  function automatic logic [7:0] msg_byte(input logic [1:0] idx, input ev_code_e code,
                                          input logic [1:0] item, input logic [3:0] price);
    case (idx)
      2'd0:    return tag_ascii(code);
      2'd1:    return ASCII_ZERO + {6'd0, item};
      2'd2:    return hex_ascii(price);
      default: return ASCII_LF;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      code_q  <= EV_IDLE;
      item_q  <= '0;
      price_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      code_q  <= code_d;
      item_q  <= item_d;
      price_q <= price_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    code_d  = code_q;
    item_d  = item_q;
    price_d = price_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_SEND;
          idx_d   = '0;
          code_d  = ev_code_e'(event_code);
          item_d  = event_item;
          price_d = event_price;
        end
      end
      S_SEND: begin
        if (eng_done) begin
          if (idx_q == 2'd3) state_d = S_IDLE;
          else               idx_d   = idx_q + 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // B0 is launched straight from the inputs so its start bit lands on the
  // cycle after accept; later bytes come from the captured copy.
  always_comb begin
    event_ready = (state_q == S_IDLE) && !eng_active;
    busy        = !event_ready;
    accept      = event_valid && event_ready;
    eng_start   = 1'b0;
    eng_data    = msg_byte(idx_q + 2'd1, code_q, item_q, price_q);
    if (accept) begin
      eng_start = 1'b1;
      eng_data  = msg_byte(2'd0, ev_code_e'(event_code), event_item, event_price);
    end else if (state_q == S_SEND && eng_done && idx_q != 2'd3) begin
      eng_start = 1'b1;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk    (clk),
    .reset  (reset),
    .start  (eng_start),
    .data   (eng_data),
    .tx     (tx),
    .done   (eng_done),
    .active (eng_active)
  );

endmodule

// File: tb/tb_vend_status_tx.sv
// Scoreboard bench for vend_status_tx: expected bytes are queued at accept
// and compared as the UART monitor decodes frames from tx.
module tb_vend_status_tx;

  localparam int CPB        = 4;
  localparam int MSG_CYCLES = 40 * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic       event_valid;
  logic [1:0] event_code;
  logic [1:0] event_item;
  logic [3:0] event_price;
  logic       event_ready;
  logic       tx;
  logic       busy;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  bit   mon_en = 1'b0;
  logic [7:0] exp_q[$];

  vend_status_tx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .event_valid (event_valid),
    .event_code  (event_code),
    .event_item  (event_item),
    .event_price (event_price),
    .event_ready (event_ready),
    .tx          (tx),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed === expected) n_pass++;
    else $display("[TB] FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, observed, expected, cyc);
  endtask

  function automatic logic [7:0] expTag(input logic [1:0] c);
    case (c)
      2'd0:    return 8'h49;
      2'd1:    return 8'h50;
      2'd2:    return 8'h44;
      default: return 8'h3F;
    endcase
  endfunction

  function automatic logic [7:0] expHex(input logic [3:0] p);
    if (p < 4'd10) return 8'h30 + {4'h0, p};
    else           return 8'h41 + {4'h0, p} - 8'd10;
  endfunction

  // Drives an event and waits for the accept; returns the accept cycle.
  task automatic applyStimulus(input logic [1:0] code, input logic [1:0] item,
                               input logic [3:0] price, input bit hold, output int a_cyc);
    bit accepted;
    accepted    = 1'b0;
    event_code  = code;
    event_item  = item;
    event_price = price;
    event_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (event_ready === 1'b1) begin
        accepted = 1'b1;
        break;
      end
    end
    a_cyc = cyc;
    if (!accepted) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
      event_valid = 1'b0;
      return;
    end
    checkOutput("tx_idle_at_accept", {31'd0, tx}, 32'd1);
    if (mon_en) begin
      exp_q.push_back(expTag(code));
      exp_q.push_back(8'h30 + {6'd0, item});
      exp_q.push_back(expHex(price));
      exp_q.push_back(8'h0A);
    end
    @(posedge clk);
    #1;
    if (!hold) event_valid = 1'b0;
    @(negedge clk);
    checkOutput("start_bit_at_A+1", {31'd0, tx}, 32'd0);
    checkOutput("busy_at_A+1", {31'd0, busy}, 32'd1);
    checkOutput("ready_low_at_A+1", {31'd0, event_ready}, 32'd0);
  endtask

  task automatic waitReady(input int a_cyc);
    bit got;
    got = 1'b0;
    for (int i = 0; i < MSG_CYCLES + 20; i++) begin
      @(negedge clk);
      if (event_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput("ready_return_cycle", got ? cyc : -1, a_cyc + MSG_CYCLES + 1);
    checkOutput("busy_clear", {31'd0, busy}, 32'd0);
  endtask

  // UART monitor: each bit must hold for CPB cycles, stop bit must be high.
  initial begin
    logic [7:0] rx;
    logic       v;
    bit         ok;
    forever begin
      @(negedge clk);
      if (mon_en && tx === 1'b0) begin
        ok = 1'b1;
        for (int j = 1; j < CPB; j++) begin
          @(negedge clk);
          if (tx !== 1'b0) ok = 1'b0;
        end
        for (int b = 0; b < 8; b++) begin
          @(negedge clk);
          v = tx;
          for (int j = 1; j < CPB; j++) begin
            @(negedge clk);
            if (tx !== v) ok = 1'b0;
          end
          rx[b] = v;
        end
        for (int j = 0; j < CPB; j++) begin
          @(negedge clk);
          if (tx !== 1'b1) ok = 1'b0;
        end
        checkOutput("bit_timing", {31'd0, ok}, 32'd1);
        if (exp_q.size() == 0) checkOutput("unexpected_byte", {24'd0, rx}, 32'hFFFF_FFFF);
        else                   checkOutput("byte", {24'd0, rx}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int a1, a2, bad_tx, bad_rdy, bad_busy, low;
    reset       = 1'b1;
    event_valid = 1'b0;
    event_code  = '0;
    event_item  = '0;
    event_price = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    bad_tx = 0; bad_rdy = 0; bad_busy = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1) bad_tx++;
      if (event_ready !== 1'b1) bad_rdy++;
      if (busy !== 1'b0) bad_busy++;
    end
    checkOutput("reset_tx_bad_cycles", bad_tx, 0);
    checkOutput("reset_ready_bad_cycles", bad_rdy, 0);
    checkOutput("reset_busy_bad_cycles", bad_busy, 0);
    mon_en = 1'b1;

    // "P27\n"
    @(posedge clk); #1;
    applyStimulus(2'd1, 2'd2, 4'd7, 1'b0, a1);
    waitReady(a1);

    // "D3C\n" then "?3F\n"
    @(posedge clk); #1;
    applyStimulus(2'd2, 2'd3, 4'd12, 1'b0, a1);
    waitReady(a1);
    @(posedge clk); #1;
    applyStimulus(2'd3, 2'd3, 4'd15, 1'b0, a1);
    waitReady(a1);

    // valid held high across two messages
    @(posedge clk); #1;
    applyStimulus(2'd2, 2'd1, 4'd9, 1'b1, a1);
    applyStimulus(2'd0, 2'd0, 4'd0, 1'b0, a2);
    checkOutput("b2b_accept_cycle", a2, a1 + MSG_CYCLES + 1);
    waitReady(a2);

    // reset during B1 aborts the message
    mon_en = 1'b0;
    @(posedge clk); #1;
    applyStimulus(2'd1, 2'd1, 4'd5, 1'b0, a1);
    while (cyc < a1 + 49) @(negedge clk);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("tx_after_reset", {31'd0, tx}, 32'd1);
    checkOutput("ready_after_reset", {31'd0, event_ready}, 32'd1);
    checkOutput("busy_after_reset", {31'd0, busy}, 32'd0);
    low = 0;
    repeat (80) begin
      @(negedge clk);
      if (tx !== 1'b1) low++;
    end
    checkOutput("no_bytes_after_reset", low, 0);
    mon_en = 1'b1;
    @(posedge clk); #1;
    applyStimulus(2'd2, 2'd0, 4'd10, 1'b0, a1);
    waitReady(a1);

    // inputs churn while the message is in flight
    @(posedge clk); #1;
    applyStimulus(2'd1, 2'd1, 4'd11, 1'b0, a1);
    repeat (140) begin
      @(posedge clk); #1;
      event_code  = 2'($urandom);
      event_item  = 2'($urandom);
      event_price = 4'($urandom);
    end
    waitReady(a1);

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
